// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM state encoding and grant encoding for the memory port arbiter.
// Pure declarations: no latency, no backpressure.
package mem_port_arbiter_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, bundled as one interface.
// Wiring only: no latency; req is held by the requester until its ready pulse.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int DATA_W = DATA_LEN
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_cancel,
    output if_rdata, if_ready, if_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Pipeline + memory side.
  modport master (
    output if_req, if_addr, if_cancel,
    input  if_rdata, if_ready, if_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_port_arbiter_grant_sel.sv
// Combinational grant picker (arb_grant_sel): data first, but never twice in a row over a waiting fetch.
// Zero latency; a port that loses simply stays pending for the next IDLE cycle.
module mem_port_arbiter_grant_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_vld,
  input  logic   d_vld,
  input  grant_t last_grant,
  output logic   grant_vld,
  output grant_t grant
);

  always_comb begin
    grant_vld = if_vld | d_vld;
    grant     = GRANT_IF;
    if (d_vld && (!if_vld || last_grant == GRANT_IF)) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM-stage requests onto one single-ported, variable-latency memory.
// Latency: grant->mem_req 1 cycle, mem_ack->ready 1 cycle; requesters hold req (and stall) until ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int DATA_W = DATA_LEN
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t        state, state_nxt;
  grant_t            last_grant, last_grant_nxt;
  grant_t            grant;
  logic              grant_vld;
  logic              drop, drop_nxt;

  logic              cmd_we, cmd_we_nxt;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_nxt;
  logic [DATA_W-1:0] cmd_wdata, cmd_wdata_nxt;

  logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;
  logic              if_ready_q, if_ready_nxt;
  logic              d_ready_q, d_ready_nxt;

  logic              if_pend;
  logic              d_pend;

  // A requester still holds req during its own ready cycle; masking it
  // there stops the same transaction from being granted a second time.
  assign if_pend = bus.if_req & ~bus.if_cancel & ~if_ready_q;
  assign d_pend  = bus.d_req & ~d_ready_q;

  mem_port_arbiter_grant_sel u_grant_sel (
    .if_vld     (if_pend),
    .d_vld      (d_pend),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    drop_nxt       = drop;
    cmd_we_nxt     = cmd_we;
    cmd_addr_nxt   = cmd_addr;
    cmd_wdata_nxt  = cmd_wdata;
    if_rdata_nxt   = if_rdata_q;
    d_rdata_nxt    = d_rdata_q;
    if_ready_nxt   = 1'b0;
    d_ready_nxt    = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (grant_vld) begin
          last_grant_nxt = grant;
          if (grant == GRANT_D) begin
            state_nxt     = ARB_D;
            cmd_we_nxt    = bus.d_we;
            cmd_addr_nxt  = bus.d_addr;
            cmd_wdata_nxt = bus.d_wdata;
          end else begin
            state_nxt    = ARB_IF;
            cmd_we_nxt   = 1'b0;
            cmd_addr_nxt = bus.if_addr;
          end
        end
      end
      ARB_IF: begin
        if (bus.mem_ack) begin
          // A redirect in the ack cycle itself also kills the pulse.
          state_nxt    = ARB_IDLE;
          if_rdata_nxt = bus.mem_rdata;
          if_ready_nxt = ~(drop | bus.if_cancel);
          drop_nxt     = 1'b0;
        end else if (bus.if_cancel) begin
          drop_nxt = 1'b1;
        end
      end
      ARB_D: begin
        if (bus.mem_ack) begin
          state_nxt   = ARB_IDLE;
          d_rdata_nxt = bus.mem_rdata;
          d_ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_IF;
      drop       <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      last_grant <= last_grant_nxt;
      drop       <= drop_nxt;
      cmd_we     <= cmd_we_nxt;
      cmd_addr   <= cmd_addr_nxt;
      cmd_wdata  <= cmd_wdata_nxt;
      if_rdata_q <= if_rdata_nxt;
      d_rdata_q  <= d_rdata_nxt;
      if_ready_q <= if_ready_nxt;
      d_ready_q  <= d_ready_nxt;
    end
  end

  // mem_req decodes the state register, so an async reset drops it at once.
  assign bus.mem_req   = (state != ARB_IDLE);
  assign bus.mem_we    = cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;

  assign bus.if_stall  = bus.if_req & ~if_ready_q;
  assign bus.d_stall   = bus.d_req & ~d_ready_q;

endmodule
